// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed driver for a common-anode style 7-segment
// display with active-low segment and digit lines.
//
// Scan: each digit is held for DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) clocks.
// New contents are staged through a one-entry pending register and promoted
// to the shadow register only at a frame boundary, so a frame never tears.
// Leading-zero blanking and per-digit decimal points are applied on decode.
// The first clock of every digit slot keeps all digit enables off so the
// segment lines settle before the next digit lights (anti-ghosting).
//
// Optional feature: define SEG7_BRIGHTNESS_EN to enable PWM dimming through
// the brightness input; otherwise brightness is ignored and each digit is lit
// for slots 1..DIV-1.

module seg7_mux_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic                    ready,
  output logic                    frame_done,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int DIV    = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int STEP   = DIV / 16;
  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Reject parameter sets the PWM step and scan counters cannot represent.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_mux_driver: NUM_DIGITS must be 1..8");
  end
  if (DIV < 16 || (DIV % 16) != 0) begin : g_bad_div
    $error("seg7_mux_driver: CLK_HZ/(REFRESH_HZ*NUM_DIGITS) must be a multiple of 16 and >= 16");
  end

  // Active-low a..g pattern for one hex nibble (bit0 = a).
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  logic [SLOT_W-1:0]       slot;
  logic [IDX_W-1:0]        idx;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_blz;

  logic [4*NUM_DIGITS-1:0] shd_value;
  logic [NUM_DIGITS-1:0]   shd_dp;
  logic                    shd_blz;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   sel_next;

  assign boundary   = (slot == SLOT_LAST) && (idx == IDX_LAST);
  assign frame_done = boundary;

  // Slot counter and digit index: slot wraps every DIV clocks, index advances on wrap.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // Load handshake: ready low means the pending register holds a frame awaiting the boundary.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ready      <= 1'b1;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blz   <= 1'b0;
      shd_value  <= '0;
      shd_dp     <= '0;
      shd_blz    <= 1'b0;
    end else if (boundary && !ready) begin
      shd_value <= pend_value;
      shd_dp    <= pend_dp;
      shd_blz   <= pend_blz;
      ready     <= 1'b1;
    end else if (load && ready) begin
      pend_value <= value;
      pend_dp    <= dp;
      pend_blz   <= blank_lz;
      ready      <= 1'b0;
    end
  end

  // Leading-zero mask: digit i blanks while every nibble from i upward is zero.
  always_comb begin
    blank_mask = '0;
    zero_above = shd_blz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (shd_value[4*i +: 4] != 4'h0) zero_above = 1'b0;
      blank_mask[i] = zero_above;
    end
  end

  // Select the nibble, decimal point and blank flag of the digit being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shd_value[4*i +: 4];
        cur_dp    = shd_dp[i];
        cur_blank = blank_mask[i];
      end
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]      bright_q;
  logic [SLOT_W:0] on_limit;

  // Brightness is captured once per digit slot so the duty cycle cannot change mid-slot.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) bright_q <= 4'h0;
    else if (slot == '0) bright_q <= brightness;
  end

  // Digit is lit from slot 1 up to (brightness+1)/16 of the slot length.
  always_comb begin
    on_limit = (SLOT_W+1)'((int'(bright_q) + 1) * STEP);
    lit      = (slot != '0) && ({1'b0, slot} < on_limit);
  end
`else
  logic unused_brightness;
  assign unused_brightness = &{1'b0, brightness};

  // Digit is lit for the whole slot except the settle cycle at slot 0.
  always_comb begin
    lit = (slot != '0);
  end
`endif

  // One-hot-low digit enable for the digit currently being scanned.
  always_comb begin
    sel_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && idx == IDX_W'(i)) sel_next[i] = 1'b0;
    end
  end

  // Output register: pins lag the scan state by one clock and are glitch-free.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      seg       <= 8'hFF;
      digit_sel <= '1;
    end else begin
      seg       <= cur_blank ? {~cur_dp, 7'h7F} : {~cur_dp, hex7(cur_nib)};
      digit_sel <= sel_next;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver with NUM_DIGITS=4, CLK_HZ=1_600_000,
// REFRESH_HZ=1000 (DIV=400, frame=1600 clocks). A cycle-count based model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_seg7_mux_driver;
  localparam int ND    = 4;
  localparam int DIV   = 400;
  localparam int FRAME = ND * DIV;
`ifdef SEG7_BRIGHTNESS_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic          clk;
  logic          nRST;
  logic          load;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dp;
  logic          blank_lz;
  logic [3:0]    brightness;
  logic          ready;
  logic          frame_done;
  logic [7:0]    seg;
  logic [ND-1:0] digit_sel;

  int checks = 0;
  int errors = 0;

  seg7_mux_driver #(.NUM_DIGITS(ND), .CLK_HZ(1_600_000), .REFRESH_HZ(1000)) dut (
    .clk(clk), .nRST(nRST), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .brightness(brightness), .ready(ready),
    .frame_done(frame_done), .seg(seg), .digit_sel(digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment letters lit for each hex glyph.
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] pins_for(input logic [3:0] nib, input logic dpb, input logic blank);
    string g;
    logic [7:0] r;
    r = 8'hFF;
    if (!blank) begin
      g = glyphs[nib];
      for (int k = 0; k < g.len(); k++) r[int'(g[k]) - 97] = 1'b0;
    end
    if (dpb) r[7] = 1'b0;
    return r;
  endfunction

  // Reference model: position in the scan is simply cycles since reset.
  int            cyc;
  logic          m_ready;
  logic [15:0]   p_val, s_val;
  logic [ND-1:0] p_dp, s_dp;
  logic          p_blz, s_blz;
  logic [3:0]    m_br;
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_sel;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cyc <= 0; m_ready <= 1'b1;
      p_val <= '0; p_dp <= '0; p_blz <= 1'b0;
      s_val <= '0; s_dp <= '0; s_blz <= 1'b0;
      m_br <= 4'h0; exp_seg <= 8'hFF; exp_sel <= '1;
    end else begin
      automatic int s = cyc % DIV;
      automatic int d = (cyc / DIV) % ND;
      automatic bit on;
      automatic logic [ND-1:0] sel = '1;
      automatic logic [15:0] upper = s_val >> (4 * d);
      if (BR_EN) on = (s >= 1) && (s < (int'(m_br) + 1) * (DIV / 16));
      else       on = (s >= 1);
      if (s == 0) m_br <= brightness;
      if (on) sel[d] = 1'b0;
      exp_sel <= sel;
      exp_seg <= pins_for(upper[3:0], s_dp[d], s_blz && d > 0 && upper == 16'h0);
      if ((cyc % FRAME) == FRAME - 1 && !m_ready) begin
        s_val <= p_val; s_dp <= p_dp; s_blz <= p_blz; m_ready <= 1'b1;
      end else if (load && m_ready) begin
        p_val <= value; p_dp <= dp; p_blz <= blank_lz; m_ready <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      chk("m_seg", seg, exp_seg);
      chk("m_digit_sel", digit_sel, exp_sel);
      chk("m_frame_done", frame_done, (cyc % FRAME) == FRAME - 1);
      chk("m_ready", ready, m_ready);
    end
  end

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done, 1'b1);
  endtask

  // Called at (or start negedges after) a boundary; checks one whole frame literally.
  task automatic check_frame(input int start, input logic [7:0] e0, e1, e2, e3);
    int n = 0;
    repeat (2 - start) @(negedge clk);
    chk("ghost_sel", digit_sel, 4'hF);
    repeat (50) @(negedge clk);
    chk("d0_sel", digit_sel, 4'b1110); chk("d0_seg", seg, e0);
    repeat (400) @(negedge clk);
    chk("d1_sel", digit_sel, 4'b1101); chk("d1_seg", seg, e1);
    repeat (400) @(negedge clk);
    chk("d2_sel", digit_sel, 4'b1011); chk("d2_seg", seg, e2);
    repeat (400) @(negedge clk);
    chk("d3_sel", digit_sel, 4'b0111); chk("d3_seg", seg, e3);
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tail", n, 348);
  endtask

  // Count lit cycles of digit 0 over one frame starting at a boundary.
  task automatic count_on(input int expected);
    int cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (digit_sel[0] == 1'b0) cnt++;
    end
    chk("d0_on_cycles", cnt, expected);
    chk("fd_period", frame_done, 1'b1);
  endtask

  initial begin
    nRST = 1'b1; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0; brightness = 4'd3;
    #1 nRST = 1'b0;
    #1;
    chk("rst_seg", seg, 8'hFF); chk("rst_sel", digit_sel, 4'hF);
    chk("rst_ready", ready, 1'b1); chk("rst_fd", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;

    // Idle scan shows "0000".
    wait_fd();
    check_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    count_on(BR_EN ? 99 : 399);

    // Load with leading-zero blanking; second load while busy is dropped.
    repeat (100) @(negedge clk);
    load = 1'b1; value = 16'h00A5; blank_lz = 1'b1; dp = '0;
    @(negedge clk);
    load = 1'b0; value = '0; blank_lz = 1'b0;
    chk("ready_after_load", ready, 1'b0);
    repeat (5) @(negedge clk);
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0; value = '0;
    chk("ready_busy", ready, 1'b0);
    wait_fd();
    chk("ready_at_boundary", ready, 1'b0);
    check_frame(0, 8'h92, 8'h88, 8'hFF, 8'hFF);
    chk("ready_restored", ready, 1'b1);

    // Load on the boundary cycle: waits a full frame before showing.
    load = 1'b1; value = 16'hB0C7; dp = 4'b0101; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0; value = '0; dp = '0;
    chk("ready_boundary_load", ready, 1'b0);
    check_frame(1, 8'h92, 8'h88, 8'hFF, 8'hFF);
    check_frame(0, 8'h78, 8'hC6, 8'h40, 8'h83);

    // Blanked digit still shows its decimal point; digit 0 never blanks.
    repeat (100) @(negedge clk);
    load = 1'b1; value = 16'h0010; dp = 4'b1000; blank_lz = 1'b1;
    @(negedge clk);
    load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
    wait_fd();
    check_frame(0, 8'hC0, 8'hF9, 8'hFF, 8'h7F);

    // Full brightness.
    brightness = 4'd15;
    count_on(399);

    // Asynchronous reset mid-slot discards a pending load.
    repeat (100) @(negedge clk);
    load = 1'b1; value = 16'h9999;
    @(negedge clk);
    load = 1'b0; value = '0;
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("arst_seg", seg, 8'hFF); chk("arst_sel", digit_sel, 4'hF);
    chk("arst_ready", ready, 1'b1); chk("arst_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    wait_fd();
    check_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
